// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//
// Purpose: shared definitions for the bit-serial adder controller.
//   - DEFAULT_WIDTH : default operand/result width.
//   - state_e       : FSM state encoding (IDLE=0, RUN=1, FIN=2).
//                     Encoding 2'd3 is unused and recovers to IDLE.
//   - cnt_width()   : width of the bit counter, clog2(WIDTH) with a
//                     minimum of one bit.
// Ports: none (package).
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // A one-bit operand still needs a one-bit counter, so clamp at 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// Full_Adder
//
// Purpose: gate-level one-bit full adder. This is the only arithmetic cell
//          in the serial adder; the controller reuses it once per bit.
// Ports:
//   X         in  1  addend bit
//   Y         in  1  addend bit
//   CARRY_IN  in  1  carry into this bit position
//   SUM       out 1  X ^ Y ^ CARRY_IN
//   CARRY_OUT out 1  majority(X, Y, CARRY_IN)
// -----------------------------------------------------------------------------
module Full_Adder (
  input  logic X,
  input  logic Y,
  input  logic CARRY_IN,
  output logic SUM,
  output logic CARRY_OUT
);

  logic half_sum;

  assign half_sum  = X ^ Y;
  assign SUM       = half_sum ^ CARRY_IN;
  // Carry is generated by X&Y or propagated through the half sum.
  assign CARRY_OUT = (X & Y) | (CARRY_IN & half_sum);

endmodule : Full_Adder

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose: bit-serial adder controller. Accepts two WIDTH-bit operands and a
//          carry-in on a START handshake, then feeds one Full_Adder with the
//          operand LSBs and a registered carry for WIDTH cycles (LSB first).
//          The final sum and carry are published together with a one-cycle
//          DONE pulse: {CARRY_OUT, SUM} = A + B + CARRY_IN.
//
// Parameters:
//   WIDTH      operand/result width, >= 1 (default 8)
//
// Ports:
//   CLK        in  1      clock, rising edge
//   RST_N      in  1      synchronous active-low reset
//   START      in  1      request, only sampled in IDLE
//   A          in  WIDTH  operand A, latched on the accepting edge
//   B          in  WIDTH  operand B, latched on the accepting edge
//   CARRY_IN   in  1      carry-in, latched on the accepting edge
//   BUSY       out 1      high while in RUN
//   DONE       out 1      one-cycle pulse, result valid
//   SUM        out WIDTH  result, held until the next DONE
//   CARRY_OUT  out 1      final carry, held until the next DONE
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CARRY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY_OUT
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q,     a_d;      // operand A, shifts right
  logic [WIDTH-1:0]   b_q,     b_d;      // operand B, shifts right
  logic               carry_q, carry_d;  // carry between bit slices
  logic [WIDTH-1:0]   acc_q,   acc_d;    // result, filled from the MSB side
  logic [CNT_W-1:0]   cnt_q,   cnt_d;    // bit index being processed
  logic [WIDTH-1:0]   sum_q,   sum_d;    // published result
  logic               cout_q,  cout_d;   // published carry
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH-1:0]   acc_shift;         // accumulator after this cycle's bit

  // ---------------------------------------------------------------------------
  // The single adder cell
  // ---------------------------------------------------------------------------
  Full_Adder u_full_adder (
    .X         (a_q[0]),
    .Y         (b_q[0]),
    .CARRY_IN  (carry_q),
    .SUM       (fa_sum),
    .CARRY_OUT (fa_cout)
  );

  // New sum bits enter at the MSB; after WIDTH shifts bit 0 of the result
  // has travelled down to position 0. A one-bit accumulator has no upper
  // part to keep, so it simply takes the sum bit.
  generate
    if (WIDTH == 1) begin : g_acc_single
      assign acc_shift = fa_sum;
    end else begin : g_acc_multi
      assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          carry_d = CARRY_IN;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d   = acc_shift;
        carry_d = fa_cout;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed result in one step so the
          // outputs never expose a partially accumulated value.
          sum_d   = acc_shift;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end

      // FIN lasts one cycle so that DONE and a new START are never
      // handled in the same state.
      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign SUM       = sum_q;
  assign CARRY_OUT = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  // WIDTH=8 instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       ci8;
  logic       busy8, done8, co8;
  logic [7:0] sum8;

  // WIDTH=1 instance
  logic       start1;
  logic [0:0] a1, b1;
  logic       ci1;
  logic       busy1, done1, co1;
  logic [0:0] sum1;

  int vectors     = 0;
  int miscompares = 0;

  // Bench-side record of the result the 8-bit DUT should be holding.
  logic [7:0] model_sum;
  logic       model_co;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start8),
    .A         (a8),
    .B         (b8),
    .CARRY_IN  (ci8),
    .BUSY      (busy8),
    .DONE      (done8),
    .SUM       (sum8),
    .CARRY_OUT (co8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start1),
    .A         (a1),
    .B         (b1),
    .CARRY_IN  (ci1),
    .BUSY      (busy1),
    .DONE      (done1),
    .SUM       (sum1),
    .CARRY_OUT (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation from IDLE. Operands are scrambled right after
  // acceptance; with glitch set a second START arrives mid-RUN.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] exp_sum, input logic exp_co,
                        input bit glitch, input string tag);
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    tick();                                   // edge k: accepted
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    check({tag, " busy@k"}, busy8, 1);
    check({tag, " done@k"}, done8, 0);
    for (int i = 1; i < 8; i++) begin
      if (glitch && i == 3) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
      end
      if (glitch && i == 4) start8 = 1'b0;
      tick();
      check({tag, " busy run"}, busy8, 1);
      check({tag, " done run"}, done8, 0);
      check({tag, " sum held run"}, sum8, model_sum);
    end
    start8 = 1'b0;
    tick();                                   // edge k+8: result
    check({tag, " done"}, done8, 1);
    check({tag, " busy fin"}, busy8, 0);
    check({tag, " sum"}, sum8, exp_sum);
    check({tag, " carry_out"}, co8, exp_co);
    model_sum = exp_sum;
    model_co  = exp_co;
    tick();                                   // edge k+9: pulse ends
    check({tag, " done clear"}, done8, 0);
    check({tag, " sum hold"}, sum8, model_sum);
    tick();
    tick();
    check({tag, " idle after"}, busy8, 0);
    check({tag, " no extra done"}, done8, 0);
    $display("op %s: A=%02h B=%02h CI=%0d -> SUM=%02h CO=%0d (want %02h %0d)",
             tag, a, b, ci, sum8, co8, exp_sum, exp_co);
  endtask

  initial begin
    int rises;
    int dones;
    int rise_at [4];
    logic prev_busy;
    logic [2:0] vv;
    logic [1:0] exp1;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    model_sum = 8'h00;
    model_co  = 1'b0;

    // Reset for two cycles, then idle with START low.
    tick();
    tick();
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst sum", sum8, 8'h00);
    check("rst carry_out", co8, 0);
    check("rst w1 busy", busy1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle busy", busy8, 0);
      check("idle done", done8, 0);
      check("idle sum", sum8, 8'h00);
    end
    $display("reset/idle checked");

    // Directed operations.
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "basic");
    run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "chain");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
    run_op(8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0, "nocarry");
    run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, "msbcarry");
    run_op(8'h29, 8'h17, 1'b0, 8'h40, 1'b0, 1'b1, "startbusy");

    // START held high: acceptances every 10 cycles, DONE for each.
    a8 = 8'h03; b8 = 8'h04; ci8 = 1'b0; start8 = 1'b1;
    rises = 0; dones = 0; prev_busy = busy8;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (busy8 && !prev_busy) begin
        if (rises < 4) rise_at[rises] = c;
        rises++;
      end
      if (done8) begin
        dones++;
        check("held sum", sum8, 8'h07);
      end
      prev_busy = busy8;
    end
    start8 = 1'b0;
    check("held acceptances", rises, 4);
    check("held dones", dones, 3);
    check("held first accept", rise_at[0], 1);
    check("held gap 1", rise_at[1] - rise_at[0], 10);
    check("held gap 3", rise_at[3] - rise_at[2], 10);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done8) dones++;
    end
    check("held last done", dones, 1);
    check("held idle", busy8, 0);
    model_sum = 8'h07;
    $display("held START: %0d acceptances, gaps %0d/%0d", rises,
             rise_at[1] - rise_at[0], rise_at[3] - rise_at[2]);

    // Reset in the middle of RUN.
    a8 = 8'h33; b8 = 8'h44; ci8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midrst busy before", busy8, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst busy", busy8, 0);
    check("midrst done", done8, 0);
    check("midrst sum", sum8, 8'h00);
    check("midrst carry_out", co8, 0);
    model_sum = 8'h00;
    model_co  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("midrst no done", done8, 0);
      check("midrst stays idle", busy8, 0);
    end
    $display("reset mid-RUN checked");
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "afterrst");

    // WIDTH=1: full-adder truth table.
    for (int v = 0; v < 8; v++) begin
      vv = v[2:0];
      a1 = vv[2]; b1 = vv[1]; ci1 = vv[0];
      exp1 = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1 = ~vv[2]; b1 = ~vv[1]; ci1 = ~vv[0];
      check("w1 busy", busy1, 1);
      check("w1 done early", done1, 0);
      tick();
      check("w1 done", done1, 1);
      check("w1 busy fin", busy1, 0);
      check("w1 result", {co1, sum1}, exp1);
      tick();
      check("w1 done clear", done1, 0);
      $display("w1: A=%0d B=%0d CI=%0d -> CO=%0d SUM=%0d (want %0d%0d)",
               vv[2], vv[1], vv[0], co1, sum1, exp1[1], exp1[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_add_ctrl
